quat_word_assembler: RTL
========================

# quat_word_assembler

Upstream feeder for the quaternion conjugate stage. It accepts a stream of 32-bit IEEE-754 single-precision words, four per quaternion in the order q0, q1, q2, q3. It assembles each group into a registered parallel quaternion (q0..q3) for the conjugate stage, with a valid/ready handshake on both sides. It also checks framing and keeps a count of delivered quaternions.

## Interface
Parameters:
- CNT_W, 16, width of the delivered-quaternion counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous reset, active low
- s_data  in  32  input word (fp32)
- s_valid  in  1  s_data is valid
- s_last  in  1  marks the final word (q3) of a quaternion
- s_ready  out  1  block accepts s_data this cycle
- q0, q1, q2, q3  out  32 each  assembled quaternion, registered
- q_valid  out  1  q0..q3 hold a quaternion
- q_ready  in  1  downstream accepts the quaternion
- frame_err  out  1  one-cycle pulse on a framing violation
- quat_cnt  out  CNT_W  count of quaternions delivered (q_valid && q_ready)
- nan_flag  out  1  a component of the held quaternion is NaN (see Configuration)

## Operation
- Word-index FSM with states W0, W1, W2, W3. The state names the slot for the next accepted word.
- Accept = s_valid && s_ready.
- s_ready:
  - 1 in W0..W2.
  - In W3, s_ready = !q_valid || q_ready. This is combinational from q_ready.
- Accept in Wk, k<3, with s_last=0: store s_data in shadow register k, advance to W(k+1).
- Accept in Wk, k<3, with s_last=1: pulse frame_err, discard the partial quaternion, go to W0. No output is produced.
- Accept in W3 with s_last=1:
  - Load q0..q2 from the shadow registers and q3 from s_data.
  - Set q_valid, go to W0.
- Accept in W3 with s_last=0: pulse frame_err, discard, go to W0. Outputs are unchanged.
- q_valid clears on q_valid && q_ready, unless a new quaternion loads in the same cycle. In that case q_valid stays 1 and the outputs take the new data.
- q0..q3 hold stable while q_valid && !q_ready.
- quat_cnt increments by 1 on every q_valid && q_ready and wraps from 2^CNT_W-1 to 0.
- Data is passed bit-exact. No arithmetic is done on the fp32 values.

## Timing
- Reset (asynchronous assert, synchronous release): FSM=W0, q0..q3=0, q_valid=0, frame_err=0, quat_cnt=0, nan_flag=0, shadow registers=0. s_ready is 1 after reset.
- Latency: q_valid rises on the edge following acceptance of q3. This is 1 cycle after the last word.
- Throughput: one word per cycle sustained, giving one quaternion per 4 cycles when q_ready=1.
- Backpressure only stalls the q3 word. Words q0..q2 of the next quaternion are absorbed while the output is held.
- frame_err is registered and high for exactly one cycle per violation.
- Reset mid-quaternion discards all partial words. The stream resynchronises at W0.

## Configuration
- QUAT_ASM_NAN_CHECK_EN:
  - Defined: nan_flag is registered together with q0..q3. It is 1 if any component has exponent 0xFF and a nonzero mantissa. It is held with the data and cleared when q_valid clears.
  - Undefined: nan_flag is tied to 0 and no check logic is built.

## Test plan
- Clean stream:
  - Stimulus: 0x3F800000, 0x40000000, 0x40400000, 0x40800000 (last on the fourth), q_ready=1.
  - Response: one cycle later q_valid=1 with q0..q3 equal to those words; quat_cnt=1 after the handshake.
- Backpressure:
  - Stimulus: q_ready=0 while a second quaternion streams in.
  - Response: q0..q2 are accepted; s_ready=0 in W3; outputs hold the first quaternion. On q_ready=1, q3 is accepted in the same cycle and the second quaternion loads with q_valid staying 1.
- Early last:
  - Stimulus: s_last=1 on the second word.
  - Response: frame_err pulses for 1 cycle, no q_valid, FSM at W0. The next 4-word quaternion is delivered correctly.
- Missing last:
  - Stimulus: 4 words with s_last=0.
  - Response: frame_err pulses and the outputs are unchanged.
- Counter wrap and reset:
  - Stimulus: CNT_W=2 and 5 quaternions, then rst_n=0 after word 2 of a sixth quaternion.
  - Response: quat_cnt reads 1 after the fifth. Reset clears everything and the following quaternion is delivered cleanly.
- NaN check (macro defined):
  - Stimulus: q2=0x7FC00000.
  - Response: nan_flag=1 with q_valid. With q2=0x7F800000 (infinity), nan_flag=0.

Source files
------------

// File: rtl/quat_word_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module   : quat_word_assembler_if
//  Brief    : Word-stream input and parallel-quaternion output bundle for
//             quat_word_assembler. The master side drives the word stream
//             and the downstream ready; the slave side is the assembler.
//  Revision : 1.0  initial release
// ============================================================================
interface quat_word_assembler_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [31:0]      q0;
  logic [31:0]      q1;
  logic [31:0]      q2;
  logic [31:0]      q3;
  logic             q_valid;
  logic             q_ready;
  logic             frame_err;
  logic [CNT_W-1:0] quat_cnt;
  logic             nan_flag;

  modport master (
    output s_data, s_valid, s_last, q_ready,
    input  s_ready, q0, q1, q2, q3, q_valid, frame_err, quat_cnt, nan_flag
  );

  modport slave (
    input  s_data, s_valid, s_last, q_ready,
    output s_ready, q0, q1, q2, q3, q_valid, frame_err, quat_cnt, nan_flag
  );
endinterface
`default_nettype wire

// File: rtl/quat_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : quat_word_assembler
//  Brief    : Collects four fp32 words (q0..q3, s_last on q3) into a
//             registered parallel quaternion with valid/ready on both sides,
//             flags framing errors and counts delivered quaternions.
//             Optional NaN detection on the held quaternion is built when
//             QUAT_ASM_NAN_CHECK_EN is defined; otherwise nan_flag is 0.
//  Revision : 1.0  initial release
// ============================================================================
module quat_word_assembler #(
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  quat_word_assembler_if.slave       bus
);

  // State names the slot that the next accepted word will fill.
  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2,
    W3 = 2'd3
  } state_t;

  state_t           r_state;
  logic [31:0]      r_sh0;
  logic [31:0]      r_sh1;
  logic [31:0]      r_sh2;
  logic [31:0]      r_q0;
  logic [31:0]      r_q1;
  logic [31:0]      r_q2;
  logic [31:0]      r_q3;
  logic             r_q_valid;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s_ready;
  logic             w_accept;
  logic             w_deliver;

  // Only the closing word can be stalled: it needs a free output slot,
  // which exists when the slot is empty or is being drained this cycle.
  assign w_s_ready = (r_state != W3) || !r_q_valid || bus.q_ready;
  assign w_accept  = bus.s_valid && w_s_ready;
  assign w_deliver = r_q_valid && bus.q_ready;

`ifdef QUAT_ASM_NAN_CHECK_EN
  logic r_nan;
  logic w_nan_in;

  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

  // NaN status of the quaternion that would load on this cycle.
  assign w_nan_in = is_nan(r_sh0) || is_nan(r_sh1) || is_nan(r_sh2) ||
                    is_nan(bus.s_data);
  assign bus.nan_flag = r_nan;
`else
  assign bus.nan_flag = 1'b0;
`endif

  // Word-index FSM, shadow capture, output load/drain and delivery counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= W0;
      r_sh0       <= 32'd0;
      r_sh1       <= 32'd0;
      r_sh2       <= 32'd0;
      r_q0        <= 32'd0;
      r_q1        <= 32'd0;
      r_q2        <= 32'd0;
      r_q3        <= 32'd0;
      r_q_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_cnt       <= '0;
`ifdef QUAT_ASM_NAN_CHECK_EN
      r_nan       <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;

      // Drain first; a load later in this block overrides the clear.
      if (w_deliver) begin
        r_q_valid <= 1'b0;
        r_cnt     <= r_cnt + CNT_W'(1);
`ifdef QUAT_ASM_NAN_CHECK_EN
        r_nan     <= 1'b0;
`endif
      end

      if (w_accept) begin
        case (r_state)
          W0: begin
            if (bus.s_last) begin
              r_frame_err <= 1'b1;
              r_state     <= W0;
            end else begin
              r_sh0   <= bus.s_data;
              r_state <= W1;
            end
          end
          W1: begin
            if (bus.s_last) begin
              r_frame_err <= 1'b1;
              r_state     <= W0;
            end else begin
              r_sh1   <= bus.s_data;
              r_state <= W2;
            end
          end
          W2: begin
            if (bus.s_last) begin
              r_frame_err <= 1'b1;
              r_state     <= W0;
            end else begin
              r_sh2   <= bus.s_data;
              r_state <= W3;
            end
          end
          W3: begin
            r_state <= W0;
            if (bus.s_last) begin
              r_q0      <= r_sh0;
              r_q1      <= r_sh1;
              r_q2      <= r_sh2;
              r_q3      <= bus.s_data;
              r_q_valid <= 1'b1;
`ifdef QUAT_ASM_NAN_CHECK_EN
              r_nan     <= w_nan_in;
`endif
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.q0        = r_q0;
  assign bus.q1        = r_q1;
  assign bus.q2        = r_q2;
  assign bus.q3        = r_q3;
  assign bus.q_valid   = r_q_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.quat_cnt  = r_cnt;

endmodule
`default_nettype wire
